// File: rtl/mem_access_arbiter_if.sv
// Bus bundle between the memory access arbiter, its three requesters
// (processing unit, operator panel, I/O unit) and the core memory block.
interface mem_access_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 31
);
  // Requester side
  logic              pu_rd_req;
  logic [ADDR_W-1:0] pu_addr;
  logic              pnl_rd_req;
  logic              pnl_wr_req;
  logic [ADDR_W-1:0] pnl_addr;
  logic [DATA_W-1:0] pnl_wdata;
  logic              io_wr_req;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic              pu_done;
  logic              pnl_done;
  logic              io_done;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              timeout_err;
  // Memory side
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read_reply;
  logic              mem_write_reply;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view
  modport master (
    input  pu_rd_req, pu_addr, pnl_rd_req, pnl_wr_req, pnl_addr, pnl_wdata,
    input  io_wr_req, io_addr, io_wdata,
    input  mem_read_reply, mem_write_reply, mem_rdata,
    output pu_done, pnl_done, io_done, rdata, busy, timeout_err,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  // Requester / memory view
  modport slave (
    output pu_rd_req, pu_addr, pnl_rd_req, pnl_wr_req, pnl_addr, pnl_wdata,
    output io_wr_req, io_addr, io_wdata,
    output mem_read_reply, mem_write_reply, mem_rdata,
    input  pu_done, pnl_done, io_done, rdata, busy, timeout_err,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// Memory access arbiter: sole owner of the core memory port. Grants PU,
// panel and I/O requests round-robin, issues one strobe per access, waits
// for the matching reply (with a watchdog) and returns done/read data.
module mem_access_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 31,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  resetn,
  mem_access_arbiter_if.master  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;
  typedef enum logic [1:0] {SRC_IO, SRC_PU, SRC_PNL} src_t;

  state_t            state;
  src_t              rr_ptr;      // first source examined in the next search
  src_t              winner;
  logic              op_wr;
  logic              mask_valid;
  logic [CNT_W-1:0]  wait_cnt;

  logic [2:0]        req_vec;
  logic              grant_any;
  src_t              grant_id;
  logic              grant_wr;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_wdata;
  logic              reply_match;
  logic              wait_expired;
  src_t              next_ptr;

  // Round-robin search over {IO, PU, PNL}; the source just served is hidden
  // for the first IDLE cycle so its level request can drop.
  always_comb begin
    logic [1:0] idx;
    idx       = '0;
    req_vec   = {bus.pnl_rd_req | bus.pnl_wr_req, bus.pu_rd_req, bus.io_wr_req};
    if (mask_valid) req_vec[winner] = 1'b0;
    grant_any = 1'b0;
    grant_id  = SRC_IO;
    for (int unsigned i = 0; i < 3; i++) begin
      idx = 2'((32'(rr_ptr) + i) % 3);
      if (!grant_any && req_vec[idx]) begin
        grant_any = 1'b1;
        grant_id  = src_t'(idx);
      end
    end
  end

  // Operands of the candidate winner; a panel write beats a panel read.
  always_comb begin
    grant_wr    = 1'b0;
    grant_addr  = '0;
    grant_wdata = '0;
    case (grant_id)
      SRC_IO: begin
        grant_wr    = 1'b1;
        grant_addr  = bus.io_addr;
        grant_wdata = bus.io_wdata;
      end
      SRC_PU: begin
        grant_addr  = bus.pu_addr;
      end
      SRC_PNL: begin
        grant_wr    = bus.pnl_wr_req;
        grant_addr  = bus.pnl_addr;
        grant_wdata = bus.pnl_wdata;
      end
      default: ;
    endcase
  end

  // WAIT exit conditions and the rotation step past the current winner.
  always_comb begin
    reply_match  = op_wr ? bus.mem_write_reply : bus.mem_read_reply;
    wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));
    next_ptr     = SRC_IO;
    case (winner)
      SRC_IO:  next_ptr = SRC_PU;
      SRC_PU:  next_ptr = SRC_PNL;
      default: next_ptr = SRC_IO;
    endcase
  end

  // Access sequencer IDLE -> ISSUE -> WAIT -> DONE with registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= ST_IDLE;
      rr_ptr          <= SRC_IO;
      winner          <= SRC_IO;
      op_wr           <= 1'b0;
      mask_valid      <= 1'b0;
      wait_cnt        <= '0;
      bus.pu_done     <= 1'b0;
      bus.pnl_done    <= 1'b0;
      bus.io_done     <= 1'b0;
      bus.rdata       <= '0;
      bus.busy        <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.mem_read    <= 1'b0;
      bus.mem_write   <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
    end else begin
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.pu_done   <= 1'b0;
      bus.pnl_done  <= 1'b0;
      bus.io_done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          mask_valid <= 1'b0;
          if (grant_any) begin
            winner        <= grant_id;
            op_wr         <= grant_wr;
            bus.mem_addr  <= grant_addr;
            bus.mem_wdata <= grant_wdata;
            bus.mem_read  <= !grant_wr;
            bus.mem_write <= grant_wr;
            bus.busy      <= 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // A matching reply takes precedence over an expiring watchdog.
          if (reply_match || wait_expired) begin
            if (reply_match && !op_wr) bus.rdata <= bus.mem_rdata;
            if (!reply_match) bus.timeout_err <= 1'b1;
            bus.io_done  <= (winner == SRC_IO);
            bus.pu_done  <= (winner == SRC_PU);
            bus.pnl_done <= (winner == SRC_PNL);
            state        <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          rr_ptr     <= next_ptr;
          mask_valid <= 1'b1;
          bus.busy   <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
